run_controller: RTL and testbench

Synthesizable run-control block that sequences a multi-core processor through reset, run and result dump. It replaces bench-only timeout and dump logic with a parametrised FSM. Termination is one of three causes: all enabled cores halted, a programmed cycle limit, or a retire-inactivity watchdog. It sits between the top-level bench/host interface and the core array, and issues a dump handshake toward the memory/register dump agent.

---
 rtl/run_controller_if.sv | 32 +++
 rtl/run_controller.sv | 132 +++++++++++++
 tb/tb_run_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// Host/core-array side signals of the run controller.
// The design uses the slave modport and the host side uses master.
interface run_controller_if #(
    parameter int unsigned N_CORES = 1,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned WDOG_W  = 16
) ();
    logic               start;
    logic [CNT_W-1:0]   run_cycles;
    logic [WDOG_W-1:0]  wdog_limit;
    logic [N_CORES-1:0] core_en;
    logic [N_CORES-1:0] halt;
    logic [N_CORES-1:0] retire;
    logic               dump_ack;
    logic               core_reset;
    logic               core_stall;
    logic               running;
    logic               dump_req;
    logic               done;
    logic [1:0]         status;
    logic [CNT_W-1:0]   cycle_count;

    modport master (
        output start, run_cycles, wdog_limit, core_en, halt, retire, dump_ack,
        input  core_reset, core_stall, running, dump_req, done, status, cycle_count
    );

    modport slave (
        input  start, run_cycles, wdog_limit, core_en, halt, retire, dump_ack,
        output core_reset, core_stall, running, dump_req, done, status, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// Run-control FSM: holds the cores in reset, runs them until halt, cycle limit
// or retire watchdog, then performs a dump handshake and parks in DONE.
module run_controller #(
    parameter int unsigned N_CORES      = 1,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned WDOG_W       = 16
) (
    input logic             clk,
    input logic             reset,
    run_controller_if.slave bus
);
    localparam int unsigned HoldW = $clog2(RESET_CYCLES + 1);

    localparam logic [1:0] StatNone    = 2'd0;
    localparam logic [1:0] StatHalt    = 2'd1;
    localparam logic [1:0] StatTimeout = 2'd2;
    localparam logic [1:0] StatHang    = 2'd3;

    typedef enum logic [2:0] {StIdle, StRstHold, StRun, StDump, StDone} state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic [WDOG_W-1:0]  wdog_limit_q, wdog_limit_d;
    logic [WDOG_W-1:0]  idle_q, idle_d;
    logic [N_CORES-1:0] core_en_q, core_en_d;
    logic [N_CORES-1:0] halted_q, halted_d;
    logic [1:0]         status_q, status_d;
    logic               hit_halt, hit_timeout, hit_hang;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        cycle_count_d = cycle_count_q;
        run_cycles_d  = run_cycles_q;
        wdog_limit_d  = wdog_limit_q;
        idle_d        = idle_q;
        core_en_d     = core_en_q;
        halted_d      = halted_q;
        status_d      = status_q;
        hit_halt      = 1'b0;
        hit_timeout   = 1'b0;
        hit_hang      = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    run_cycles_d = bus.run_cycles;
                    wdog_limit_d = bus.wdog_limit;
                    core_en_d    = bus.core_en;
                    hold_d       = HoldW'(RESET_CYCLES);
                    status_d     = StatNone;
                    state_d      = StRstHold;
                end
            end
            StRstHold: begin
                if (hold_q == HoldW'(1)) begin
                    cycle_count_d = '0;
                    halted_d      = '0;
                    idle_d        = '0;
                    state_d       = StRun;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            StRun: begin
                cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
                halted_d      = halted_q | (bus.halt & core_en_q);
                if (|(bus.retire & core_en_q)) begin
                    idle_d = '0;
                end else begin
                    idle_d = (&idle_q) ? idle_q : idle_q + WDOG_W'(1);
                end
                // Exit conditions look at next-state values so the run ends on the
                // same edge that records the final halt/count/idle update.
                hit_halt    = (core_en_q != '0) && ((halted_d & core_en_q) == core_en_q);
                hit_timeout = (run_cycles_q != '0) && (cycle_count_d == run_cycles_q);
                hit_hang    = (wdog_limit_q != '0) && (idle_d == wdog_limit_q);
                if (hit_halt) begin
                    status_d = StatHalt;
                    state_d  = StDump;
                end else if (hit_timeout) begin
                    status_d = StatTimeout;
                    state_d  = StDump;
                end else if (hit_hang) begin
                    status_d = StatHang;
                    state_d  = StDump;
                end
            end
            StDump: begin
                if (bus.dump_ack) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            cycle_count_q <= '0;
            run_cycles_q  <= '0;
            wdog_limit_q  <= '0;
            idle_q        <= '0;
            core_en_q     <= '0;
            halted_q      <= '0;
            status_q      <= StatNone;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            cycle_count_q <= cycle_count_d;
            run_cycles_q  <= run_cycles_d;
            wdog_limit_q  <= wdog_limit_d;
            idle_q        <= idle_d;
            core_en_q     <= core_en_d;
            halted_q      <= halted_d;
            status_q      <= status_d;
        end
    end

    assign bus.core_reset  = (state_q == StIdle) || (state_q == StRstHold);
    assign bus.core_stall  = (state_q == StDump) || (state_q == StDone);
    assign bus.running     = (state_q == StRun);
    assign bus.dump_req    = (state_q == StDump);
    assign bus.done        = (state_q == StDone);
    assign bus.status      = status_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a table of complete runs plus hand-written
// sequences for reset values and reset during a pending dump.
module tb_run_controller;
    localparam int unsigned N_CORES      = 2;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned WDOG_W       = 16;

    logic clk;
    logic reset;

    run_controller_if #(.N_CORES(N_CORES), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) bus ();

    run_controller #(
        .N_CORES     (N_CORES),
        .CNT_W       (CNT_W),
        .RESET_CYCLES(RESET_CYCLES),
        .WDOG_W      (WDOG_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [31:0] rc;
        logic [15:0] wd;
        int          h0;         // RUN cycle of halt[0] pulse, -1 none
        int          h1;
        int          rstop;      // retire=2'b11 while cycle < rstop
        int          start_cyc;  // stray start/dump_ack pulse during RUN, -1 none
        logic [1:0]  exp_status;
        int          exp_count;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  hold;
        int  guard;
        int  c;
        bit  cnt_ok;
        bit  frz_ok;
        string tag;
        tag = $sformatf("v%0d", idx);

        @(negedge clk);
        bus.run_cycles = v.rc;
        bus.wdog_limit = v.wd;
        bus.core_en    = v.en;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        // Scramble the latched inputs; the DUT must keep the sampled values.
        bus.run_cycles = 32'd3;
        bus.wdog_limit = 16'd2;
        bus.core_en    = ~v.en;
        chk({tag, " done_cleared"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " status_cleared"}, {30'd0, bus.status}, 32'd0);

        hold  = 0;
        guard = 0;
        while (!bus.running && guard < 20) begin
            if (bus.core_reset) hold++;
            @(negedge clk);
            guard++;
        end
        chk({tag, " reset_hold_len"}, hold, RESET_CYCLES);
        chk({tag, " running"}, {31'd0, bus.running}, 32'd1);

        c      = 0;
        cnt_ok = 1'b1;
        while (bus.running && c < 200) begin
            if (bus.cycle_count !== c || bus.core_reset !== 1'b0) cnt_ok = 1'b0;
            bus.halt[0]  = (c == v.h0);
            bus.halt[1]  = (c == v.h1);
            bus.retire   = (c < v.rstop) ? 2'b11 : 2'b00;
            bus.start    = (c == v.start_cyc);
            bus.dump_ack = (c == v.start_cyc);
            @(negedge clk);
            c++;
        end
        bus.halt     = '0;
        bus.retire   = '0;
        bus.start    = 1'b0;
        bus.dump_ack = 1'b0;
        chk({tag, " count_seq"}, {31'd0, cnt_ok}, 32'd1);
        chk({tag, " run_len"}, c, v.exp_count);
        chk({tag, " dump_req"}, {31'd0, bus.dump_req}, 32'd1);
        chk({tag, " status"}, {30'd0, bus.status}, {30'd0, v.exp_status});
        chk({tag, " cycle_count"}, bus.cycle_count, v.exp_count);

        frz_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dump_req !== 1'b1 || bus.running !== 1'b0 || bus.core_stall !== 1'b1 ||
                bus.cycle_count !== v.exp_count) frz_ok = 1'b0;
        end
        chk({tag, " dump_hold"}, {31'd0, frz_ok}, 32'd1);

        bus.dump_ack = 1'b1;
        @(negedge clk);
        bus.dump_ack = 1'b0;
        chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " dump_req_drop"}, {31'd0, bus.dump_req}, 32'd0);
        chk({tag, " done_stall"}, {31'd0, bus.core_stall}, 32'd1);
        chk({tag, " done_status"}, {30'd0, bus.status}, {30'd0, v.exp_status});
        chk({tag, " done_count"}, bus.cycle_count, v.exp_count);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " core_reset"}, {31'd0, bus.core_reset}, 32'd1);
        chk({tag, " core_stall"}, {31'd0, bus.core_stall}, 32'd0);
        chk({tag, " running"}, {31'd0, bus.running}, 32'd0);
        chk({tag, " dump_req"}, {31'd0, bus.dump_req}, 32'd0);
        chk({tag, " done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " status"}, {30'd0, bus.status}, 32'd0);
        chk({tag, " cycle_count"}, bus.cycle_count, 32'd0);
    endtask

    initial begin
        int guard;
        //          en     rc      wd     h0  h1  rstop start status count
        vecs[0] = '{2'b11, 32'd0,  16'd0, 10, 20, 1000, -1,  2'd1,  21};
        vecs[1] = '{2'b11, 32'd50, 16'd0, -1, -1, 1000, 10,  2'd2,  50};
        vecs[2] = '{2'b11, 32'd0,  16'd8, -1, -1, 5,    -1,  2'd3,  13};
        vecs[3] = '{2'b11, 32'd13, 16'd8, -1, -1, 5,    -1,  2'd2,  13};
        vecs[4] = '{2'b11, 32'd30, 16'd0, 29, 29, 1000, -1,  2'd1,  30};
        vecs[5] = '{2'b01, 32'd0,  16'd0, 15, 3,  1000, -1,  2'd1,  16};
        vecs[6] = '{2'b00, 32'd0,  16'd5, 2,  2,  1000, -1,  2'd3,  5};
        vecs[7] = '{2'b11, 32'd0,  16'd0, 0,  0,  1000, -1,  2'd1,  1};
        vecs[8] = '{2'b11, 32'd0,  16'd1, -1, -1, 0,    -1,  2'd3,  1};
        vecs[9] = '{2'b10, 32'd40, 16'd0, 39, -1, 1000, -1,  2'd2,  40};

        bus.start      = 1'b0;
        bus.run_cycles = '0;
        bus.wdog_limit = '0;
        bus.core_en    = '0;
        bus.halt       = '0;
        bus.retire     = '0;
        bus.dump_ack   = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset while a dump is pending: abandon it asynchronously.
        @(negedge clk);
        bus.core_en    = 2'b11;
        bus.run_cycles = '0;
        bus.wdog_limit = '0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard     = 0;
        while (!bus.running && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        bus.halt = 2'b11;
        @(negedge clk);
        bus.halt = '0;
        chk("mid_dump dump_req", {31'd0, bus.dump_req}, 32'd1);
        chk("mid_dump cycle_count", bus.cycle_count, 32'd3);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset        = 1'b0;
        bus.dump_ack = 1'b1;
        @(negedge clk);
        bus.dump_ack = 1'b0;
        @(negedge clk);
        chk("late_ack dump_req", {31'd0, bus.dump_req}, 32'd0);
        chk("late_ack done", {31'd0, bus.done}, 32'd0);
        chk("late_ack core_reset", {31'd0, bus.core_reset}, 32'd1);

        run_vec(vecs[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
